// File: rtl/pattern_detector.sv
// rtl/pattern_detector.sv - serial bit-pattern detector with per-bit mask and match counter
//
// Optional feature macro: PATTERN_DETECTOR_MATCH_COUNT_EN
//   defined   : match_count counts matches (saturating) and count_clr clears it
//   undefined : match_count is tied to 0 and count_clr is ignored
//
// Parameters
//   W          pattern / shift-register width (2..32)
//   CNT_W      match counter width
// Ports
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   load           in   capture pattern and mask, restart the fill
//   pattern [W]    in   reference pattern, bit W-1 is the oldest received bit
//   mask    [W]    in   per-bit compare enable (1 = compare, 0 = don't care)
//   serial_in      in   serial data bit
//   in_valid       in   serial_in is valid this cycle
//   overlap        in   1 = overlapping detection, 0 = non-overlapping
//   count_clr      in   synchronous clear of match_count
//   pattern_match  out  one-cycle registered match pulse
//   armed          out  a pattern has been loaded since reset
//   match_count    out  saturating match count

module pattern_detector #(
   parameter int W     = 6,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [W-1:0]     pattern,
   input  logic [W-1:0]     mask,
   input  logic             serial_in,
   input  logic             in_valid,
   input  logic             overlap,
   input  logic             count_clr,
   output logic             pattern_match,
   output logic             armed,
   output logic [CNT_W-1:0] match_count
);

   // The fill counter only has to reach W-1: the W-th accepted bit is
   // recognised by the counter sitting at W-1 while a bit is accepted.
   localparam int             FW        = (W > 1) ? $clog2(W) : 1;
   localparam logic [FW-1:0]  FILL_LAST = FW'(W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      HUNT = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    sr_q;
   logic [W-1:0]    sr_next;
   logic [W-1:0]    pattern_q;
   logic [W-1:0]    mask_q;
   logic [FW-1:0]   fill_q, fill_d;
   logic            match_q;
   logic            armed_q;
   logic            accept;
   logic            window_full;
   logic            match_hit;

   // A bit is taken only once a pattern exists and load is not competing
   // for the same cycle; a load-cycle bit is dropped on purpose.
   always_comb begin
      accept  = in_valid && !load && (state_q != IDLE);
      sr_next = sr_q;
      if (accept) begin
         sr_next = {sr_q[W-2:0], serial_in};
      end
      window_full = (state_q == HUNT) || ((state_q == FILL) && (fill_q == FILL_LAST));
      match_hit   = accept && window_full && (((sr_next ^ pattern_q) & mask_q) == '0);
   end

   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      if (load) begin
         state_d = FILL;
         fill_d  = '0;
      end else if (accept) begin
         if (state_q == FILL) begin
            if (fill_q == FILL_LAST) begin
               state_d = HUNT;
            end else begin
               fill_d = fill_q + FW'(1);
            end
         end
         // overlap is looked at only here, on the match cycle itself.
         if (match_hit && !overlap) begin
            state_d = FILL;
            fill_d  = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         fill_q    <= '0;
         sr_q      <= '0;
         pattern_q <= '0;
         mask_q    <= '0;
         match_q   <= 1'b0;
         armed_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         match_q <= match_hit;
         if (accept) begin
            sr_q <= sr_next;
         end
         if (load) begin
            pattern_q <= pattern;
            mask_q    <= mask;
            armed_q   <= 1'b1;
         end
      end
   end

   assign pattern_match = match_q;
   assign armed         = armed_q;

`ifdef PATTERN_DETECTOR_MATCH_COUNT_EN
   logic [CNT_W-1:0] count_q;

   // Clear wins over a same-cycle match; the count sticks at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (count_clr) begin
         count_q <= '0;
      end else if (match_hit && (count_q != {CNT_W{1'b1}})) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign match_count = count_q;
`else
   logic unused_count_clr;

   assign unused_count_clr = count_clr;
   assign match_count      = '0;
`endif

endmodule

// File: tb/tb_pattern_detector.sv
// tb/tb_pattern_detector.sv - self-checking bench for pattern_detector

module tb_pattern_detector;

   localparam int W     = 6;
   localparam int CNT_W = 2;

   logic             clk       = 1'b0;
   logic             rst_n     = 1'b0;
   logic             load      = 1'b0;
   logic [W-1:0]     pattern   = '0;
   logic [W-1:0]     mask      = '0;
   logic             serial_in = 1'b0;
   logic             in_valid  = 1'b0;
   logic             overlap   = 1'b0;
   logic             count_clr = 1'b0;
   logic             pattern_match;
   logic             armed;
   logic [CNT_W-1:0] match_count;

   pattern_detector #(.W(W), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .load          (load),
      .pattern       (pattern),
      .mask          (mask),
      .serial_in     (serial_in),
      .in_valid      (in_valid),
      .overlap       (overlap),
      .count_clr     (count_clr),
      .pattern_match (pattern_match),
      .armed         (armed),
      .match_count   (match_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       ld;
      logic [5:0] pat;
      logic [5:0] msk;
      logic       sin;
      logic       vld;
      logic       ovl;
      logic       clr;
      logic       em;
      logic [1:0] ec;
      logic       ea;
   } vec_t;

   typedef struct {
      logic       em;
      logic [1:0] ec;
      logic       ea;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic logic [1:0] cnt_exp(input logic [1:0] c);
`ifdef PATTERN_DETECTOR_MATCH_COUNT_EN
      return c;
`else
      return 2'd0;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void add(input logic ld, input logic [5:0] pat, input logic [5:0] msk,
                               input logic sin, input logic vld, input logic ovl, input logic clr,
                               input logic em, input logic [1:0] ec, input logic ea);
      vec_t v;
      v.ld = ld; v.pat = pat; v.msk = msk; v.sin = sin; v.vld = vld;
      v.ovl = ovl; v.clr = clr; v.em = em; v.ec = ec; v.ea = ea;
      vecs.push_back(v);
   endfunction

   function automatic void ldv(input logic [5:0] pat, input logic [5:0] msk,
                               input logic ovl, input logic clr, input logic [1:0] ec);
      add(1'b1, pat, msk, 1'b0, 1'b0, ovl, clr, 1'b0, ec, 1'b1);
   endfunction

   function automatic void bitv(input logic sin, input logic ovl, input logic clr,
                                input logic em, input logic [1:0] ec);
      add(1'b0, 6'd0, 6'd0, sin, 1'b1, ovl, clr, em, ec, 1'b1);
   endfunction

   function automatic void idlev(input logic clr, input logic [1:0] ec);
      add(1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, clr, 1'b0, ec, 1'b1);
   endfunction

   // Sends the low n bits of word, oldest (word[n-1]) first; only the last
   // bit carries a possible match and count change.
   function automatic void bits(input logic [7:0] word, input int n, input logic ovl,
                                input logic [1:0] ec_pre, input logic m_last,
                                input logic [1:0] ec_last);
      for (int i = n - 1; i >= 0; i--) begin
         if (i == 0) bitv(word[i], ovl, 1'b0, m_last, ec_last);
         else        bitv(word[i], ovl, 1'b0, 1'b0, ec_pre);
      end
   endfunction

   task automatic apply(input vec_t v, input string tag);
      exp_t e;
      load      = v.ld;
      pattern   = v.pat;
      mask      = v.msk;
      serial_in = v.sin;
      in_valid  = v.vld;
      overlap   = v.ovl;
      count_clr = v.clr;
      e.em = v.em; e.ec = v.ec; e.ea = v.ea;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({tag, " match"}, 32'(pattern_match), 32'(e.em));
      chk({tag, " armed"}, 32'(armed), 32'(e.ea));
      chk({tag, " count"}, 32'(match_count), 32'(cnt_exp(e.ec)));
   endtask

   task automatic run_vecs(input string grp);
      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i], $sformatf("%s[%0d]", grp, i));
      end
      vecs.delete();
   endtask

   task automatic idle_inputs();
      load = 1'b0; in_valid = 1'b0; serial_in = 1'b0;
      count_clr = 1'b0; overlap = 1'b0;
   endtask

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset match", 32'(pattern_match), 32'd0);
      chk("reset armed", 32'(armed), 32'd0);
      chk("reset count", 32'(match_count), 32'd0);
      rst_n = 1'b1;

      // IDLE ignores data before any load
      add(1'b0, 6'd0, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
      // basic full-mask match with a gap cycle inside the fill
      ldv(6'b101101, 6'b111111, 1'b1, 1'b1, 2'd0);
      bits(8'b101, 3, 1'b1, 2'd0, 1'b0, 2'd0);
      idlev(1'b0, 2'd0);
      bits(8'b101, 3, 1'b1, 2'd0, 1'b1, 2'd1);
      idlev(1'b0, 2'd1);
      // overlapping: matches after bits 6 and 8
      ldv(6'b101010, 6'b111111, 1'b1, 1'b1, 2'd0);
      bits(8'b101010, 6, 1'b1, 2'd0, 1'b1, 2'd1);
      bitv(1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
      bitv(1'b0, 1'b1, 1'b0, 1'b1, 2'd2);
      idlev(1'b0, 2'd2);
      // non-overlapping: overlap toggled off-match has no effect
      ldv(6'b101010, 6'b111111, 1'b0, 1'b1, 2'd0);
      bits(8'b10101, 5, 1'b1, 2'd0, 1'b0, 2'd0);
      bitv(1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
      bitv(1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
      bitv(1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
      bits(8'b1010, 4, 1'b0, 2'd1, 1'b1, 2'd2);
      idlev(1'b0, 2'd2);
      // masked compare, two runs with different don't-care bits, then a miss
      ldv(6'b100001, 6'b110011, 1'b0, 1'b1, 2'd0);
      bits(8'b101101, 6, 1'b0, 2'd0, 1'b1, 2'd1);
      ldv(6'b100001, 6'b110011, 1'b0, 1'b0, 2'd1);
      bits(8'b100001, 6, 1'b0, 2'd1, 1'b1, 2'd2);
      bits(8'b001101, 6, 1'b0, 2'd2, 1'b0, 2'd2);
      idlev(1'b0, 2'd2);
      // load colliding with a valid bit: bit dropped, fill restarts
      ldv(6'b101101, 6'b111111, 1'b0, 1'b1, 2'd0);
      bits(8'b101, 3, 1'b0, 2'd0, 1'b0, 2'd0);
      add(1'b1, 6'b101101, 6'b111111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
      bits(8'b101101, 6, 1'b0, 2'd0, 1'b1, 2'd1);
      idlev(1'b0, 2'd1);
      // mask 0: every bit matches, counter saturates, clear beats increment
      ldv(6'b000000, 6'b000000, 1'b1, 1'b1, 2'd0);
      bits(8'b101100, 6, 1'b1, 2'd0, 1'b1, 2'd1);
      bitv(1'b1, 1'b1, 1'b0, 1'b1, 2'd2);
      bitv(1'b0, 1'b1, 1'b0, 1'b1, 2'd3);
      bitv(1'b1, 1'b1, 1'b0, 1'b1, 2'd3);
      bitv(1'b1, 1'b1, 1'b0, 1'b1, 2'd3);
      bitv(1'b0, 1'b1, 1'b0, 1'b1, 2'd3);
      bitv(1'b1, 1'b1, 1'b1, 1'b1, 2'd0);
      bitv(1'b0, 1'b1, 1'b0, 1'b1, 2'd1);
      idlev(1'b1, 2'd0);
      bitv(1'b1, 1'b1, 1'b0, 1'b1, 2'd1);
      idlev(1'b0, 2'd1);
      run_vecs("tbl");

      // reset in the middle of a fill
      ldv(6'b101101, 6'b111111, 1'b1, 1'b0, 2'd1);
      bits(8'b101, 3, 1'b1, 2'd1, 1'b0, 2'd1);
      run_vecs("pre_rst");
      idle_inputs();
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst match", 32'(pattern_match), 32'd0);
      chk("midrst armed", 32'(armed), 32'd0);
      chk("midrst count", 32'(match_count), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 5; i >= 0; i--) begin
         logic [5:0] w;
         w = 6'b101101;
         add(1'b0, 6'd0, 6'd0, w[i], 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
      end
      ldv(6'b101101, 6'b111111, 1'b1, 1'b0, 2'd0);
      bits(8'b101101, 6, 1'b1, 2'd0, 1'b1, 2'd1);
      idlev(1'b0, 2'd1);
      run_vecs("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pattern_detector.md
PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 SHALL have parameter W, default 6, pattern and shift-register width (2..32).
REQ-002 SHALL have parameter CNT_W, default 8, match-counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port load  input  1  capture pattern and mask this cycle.
REQ-006 SHALL have port pattern  input  W  reference pattern; bit W-1 is the oldest received bit.
REQ-007 SHALL have port mask  input  W  compare enable per bit; 1 = compare, 0 = don't-care.
REQ-008 SHALL have port serial_in  input  1  serial data bit.
REQ-009 SHALL have port in_valid  input  1  serial_in is valid this cycle.
REQ-010 SHALL have port overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-011 SHALL have port count_clr  input  1  synchronous clear of match_count.
REQ-012 SHALL have port pattern_match  output  1  one-cycle registered match pulse.
REQ-013 SHALL have port armed  output  1  a pattern has been loaded since reset.
REQ-014 SHALL have port match_count  output  CNT_W  saturating number of matches.

Function
REQ-015 SHALL implement FSM states IDLE, FILL, HUNT; reset state IDLE.
REQ-016 SHALL, in IDLE, ignore in_valid; load moves to FILL.
REQ-017 SHALL, on load in any state, register pattern/mask, clear the fill counter, and enter FILL; shift-register contents retained.
REQ-018 SHALL give load priority over in_valid in the same cycle; that serial bit is discarded.
REQ-019 SHALL, on in_valid (no load, not IDLE), shift: sr <= {sr[W-2:0], serial_in}.
REQ-020 SHALL in FILL count accepted bits; the W-th accepted bit moves the FSM to HUNT and is evaluated for a match in that same cycle.
REQ-021 SHALL evaluate a match only on a cycle with an accepted bit and W valid bits: ((sr_next ^ pattern_reg) & mask_reg) == 0.
REQ-022 SHALL assert pattern_match for exactly one cycle, the cycle after the completing bit (latency 1 clk).
REQ-023 SHALL, in overlap=1, stay in HUNT after a match, so every further bit may match.
REQ-024 SHALL, in overlap=0, after a match clear the fill counter and return to FILL, requiring W new bits before the next match.
REQ-025 SHALL treat mask == 0 as always-match once W bits are valid.
REQ-026 SHALL sample overlap only on a match cycle; changes elsewhere have no effect.
REQ-027 SHALL increment match_count by 1 per match and saturate at 2^CNT_W-1 (no wrap).
REQ-028 SHALL give count_clr priority over a same-cycle increment (result 0).
REQ-029 SHALL hold armed=1 from the cycle after the first load until reset.

Reset
REQ-030 SHALL, on rst_n low, asynchronously clear sr, pattern/mask registers, fill counter, FSM (IDLE), pattern_match=0, armed=0, match_count=0.
REQ-031 SHALL, on reset mid-operation, abandon any partial fill; a new load is required before detection resumes.

Configuration
REQ-032 SHALL use macro PATTERN_DETECTOR_MATCH_COUNT_EN.
REQ-033 SHALL, with the macro defined, implement match_count and count_clr per REQ-027/028.
REQ-034 SHALL, without the macro, drive match_count constant 0, ignore count_clr, and omit the counter logic; all other behaviour identical.

Verification
REQ-035 SHALL cover: W=6, load pattern=101101 mask=111111, send bits 1,0,1,1,0,1 -> pattern_match pulses once, 1 clk after the 6th bit; match_count=1.
REQ-036 SHALL cover: overlap=1, pattern=101010, stream 10101010 -> matches after bits 6 and 8 (2 pulses); overlap=0 same stream -> 1 pulse.
REQ-037 SHALL cover: mask=110011 pattern=100001, stream 10xx01 with xx=11 then new load and xx=00 -> match in both runs.
REQ-038 SHALL cover: load asserted with in_valid=1 at bit 4 -> bit discarded, no match until 6 further valid bits.
REQ-039 SHALL cover: CNT_W=2, mask=000000, overlap=1, 6 bits then 5 more -> match_count saturates at 3; count_clr with match in same cycle -> 0.
REQ-040 SHALL cover: rst_n low after 3 bits in FILL -> all outputs 0, armed=0, no match on further bits until load.
